// File: rtl/ss_chan_buf_if.sv
// Channel-side signal bundle for ss_chan_buf: control, source bus, module and sink bus.
// The slave modport is the buffer's view; master is the surrounding engine/module.
interface ss_chan_buf_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned CW = 24
);
  logic          ch_go;
  logic [CW-1:0] ch_cnt;
  logic          ch_abort;
  logic          ch_busy;
  logic          ch_done;
  logic          ch_err;
  logic          ss_start0;
  logic          ss_xfer0;
  logic [DW-1:0] wbs_dat_o0;
  logic          ss_end0;
  logic          m_src_getn;
  logic [DW-1:0] m_src;
  logic          m_last;
  logic          m_src_empty;
  logic          m_dst_putn;
  logic [DW-1:0] m_dst;
  logic          m_dst_full;
  logic          ss_start1;
  logic          ss_xfer1;
  logic [DW-1:0] wbs_dat_i1;
  logic          ss_end1;

  modport slave (
    input  ch_go, ch_cnt, ch_abort, ss_xfer0, wbs_dat_o0, m_src_getn,
           m_dst_putn, m_dst, ss_xfer1,
    output ch_busy, ch_done, ch_err, ss_start0, ss_end0, m_src, m_last,
           m_src_empty, m_dst_full, ss_start1, wbs_dat_i1, ss_end1
  );

  modport master (
    output ch_go, ch_cnt, ch_abort, ss_xfer0, wbs_dat_o0, m_src_getn,
           m_dst_putn, m_dst, ss_xfer1,
    input  ch_busy, ch_done, ch_err, ss_start0, ss_end0, m_src, m_last,
           m_src_empty, m_dst_full, ss_start1, wbs_dat_i1, ss_end1
  );
endinterface

// File: rtl/ss_chan_buf.sv
// DMA channel buffer: FWFT source FIFO (data+last) and FWFT destination FIFO with a
// beat-counting IDLE/RUN/DONE channel FSM. Define SS_CHAN_ERR_EN to build ch_err detection.
module ss_chan_buf #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 9,
  parameter int unsigned CW = 24
) (
  input logic          wb_clk_i,
  input logic          wb_rst_i,
  ss_chan_buf_if.slave bus
);
  localparam int unsigned DEPTH = 2**AW;
  localparam logic [AW:0] PONE  = 1;
  localparam logic [CW-1:0] CONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sw;
  logic [CW-1:0] dr;

  logic [AW:0]   s_wp, s_rp, d_wp, d_rp;
  logic [DW:0]   s_mem [DEPTH];
  logic [DW-1:0] d_mem [DEPTH];
  logic [DW:0]   s_head;
  logic [DW-1:0] d_head;

  logic s_empty, s_full, d_empty, d_full;
  logic running, src_room, s_last_in;
  logic s_push, s_pop, d_push, d_pop;

  assign s_empty = (s_wp == s_rp);
  assign s_full  = (s_wp[AW] != s_rp[AW]) && (s_wp[AW-1:0] == s_rp[AW-1:0]);
  assign d_empty = (d_wp == d_rp);
  assign d_full  = (d_wp[AW] != d_rp[AW]) && (d_wp[AW-1:0] == d_rp[AW-1:0]);

  assign running   = (state == RUN);
  assign src_room  = (sw < cnt);
  assign s_last_in = (sw == cnt - CONE);

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign s_pop  = ~bus.m_src_getn & ~s_empty;
  assign s_push = running & bus.ss_xfer0 & src_room & (~s_full | s_pop);
  assign d_pop  = bus.ss_xfer1 & ~d_empty;
  assign d_push = ~bus.m_dst_putn & (~d_full | d_pop);

  assign s_head = s_mem[s_rp[AW-1:0]];
  assign d_head = d_mem[d_rp[AW-1:0]];

  assign bus.ss_start0   = running & ~s_full & src_room;
  assign bus.ss_end0     = s_push & s_last_in;
  assign bus.m_src       = s_empty ? '0 : s_head[DW-1:0];
  assign bus.m_last      = ~s_empty & s_head[DW];
  assign bus.m_src_empty = s_empty;
  assign bus.m_dst_full  = d_full;
  assign bus.ss_start1   = ~d_empty;
  assign bus.wbs_dat_i1  = d_empty ? '0 : d_head;
  assign bus.ss_end1     = running & d_pop & (dr == cnt - CONE);
  assign bus.ch_busy     = busy_q;
  assign bus.ch_done     = done_q;

  always_ff @(posedge wb_clk_i) begin
    if (s_push) s_mem[s_wp[AW-1:0]] <= {s_last_in, bus.wbs_dat_o0};
    if (d_push) d_mem[d_wp[AW-1:0]] <= bus.m_dst;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      sw     <= '0;
      dr     <= '0;
      s_wp   <= '0;
      s_rp   <= '0;
      d_wp   <= '0;
      d_rp   <= '0;
    end else if (bus.ch_abort) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      sw     <= '0;
      dr     <= '0;
      s_wp   <= '0;
      s_rp   <= '0;
      d_wp   <= '0;
      d_rp   <= '0;
    end else begin
      if (s_push) begin
        s_wp <= s_wp + PONE;
        sw   <= sw + CONE;
      end
      if (s_pop)  s_rp <= s_rp + PONE;
      if (d_push) d_wp <= d_wp + PONE;
      if (d_pop) begin
        d_rp <= d_rp + PONE;
        dr   <= dr + CONE;
      end
      done_q <= 1'b0;
      // Counter clears below sit after the increments so they take precedence.
      case (state)
        IDLE: begin
          if (bus.ch_go) begin
            if (bus.ch_cnt != '0) begin
              cnt    <= bus.ch_cnt;
              sw     <= '0;
              dr     <= '0;
              state  <= RUN;
              busy_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.ss_end1) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SS_CHAN_ERR_EN
  logic err_q;
  logic err_ev;

  // Accesses that the FIFOs accept (push into full with a matching pop) are not errors.
  assign err_ev = (bus.ss_xfer0 & ((s_full & ~s_pop) | (sw == cnt)))
                | (~bus.m_src_getn & s_empty)
                | (~bus.m_dst_putn & d_full & ~d_pop)
                | (bus.ss_xfer1 & d_empty);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      err_q <= 1'b0;
    else if (bus.ch_abort || (state == IDLE && bus.ch_go))
      err_q <= 1'b0;
    else if (err_ev)
      err_q <= 1'b1;
  end

  assign bus.ch_err = err_q;
`else
  assign bus.ch_err = 1'b0;
`endif
endmodule

// File: tb/tb_ss_chan_buf.sv
// Directed bench for ss_chan_buf with a 4-entry FIFO configuration (AW=2, DW=16, CW=8).
module tb_ss_chan_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef SS_CHAN_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  ss_chan_buf_if #(.DW(16), .CW(8)) bus ();

  ss_chan_buf #(.DW(16), .AW(2), .CW(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    bus.ch_go = 1'b0;      bus.ch_cnt = '0;      bus.ch_abort = 1'b0;
    bus.ss_xfer0 = 1'b0;   bus.wbs_dat_o0 = '0;  bus.m_src_getn = 1'b1;
    bus.m_dst_putn = 1'b1; bus.m_dst = '0;       bus.ss_xfer1 = 1'b0;
    tick; tick;

    // reset state
    check("rst_src_empty", bus.m_src_empty, 1);
    check("rst_busy",      bus.ch_busy, 0);
    check("rst_done",      bus.ch_done, 0);
    check("rst_err",       bus.ch_err, 0);
    check("rst_start0",    bus.ss_start0, 0);
    check("rst_start1",    bus.ss_start1, 0);
    check("rst_dst_full",  bus.m_dst_full, 0);
    check("rst_m_src",     bus.m_src, 0);
    rst = 1'b0;
    tick;

    // reset mid-RUN with 3 beats queued
    bus.ch_cnt = 8'd4; bus.ch_go = 1'b1; tick; bus.ch_go = 1'b0;
    check("t1_busy", bus.ch_busy, 1);
    for (int i = 0; i < 3; i++) begin
      bus.ss_xfer0 = 1'b1; bus.wbs_dat_o0 = 16'h0A00 + 16'(i); tick;
    end
    bus.ss_xfer0 = 1'b0;
    check("t1_queued",  bus.m_src_empty, 0);
    check("t1_head",    bus.m_src, 16'h0A00);
    #1 rst = 1'b1;
    #1;
    check("t1_rst_empty",  bus.m_src_empty, 1);
    check("t1_rst_busy",   bus.ch_busy, 0);
    check("t1_rst_start0", bus.ss_start0, 0);
    check("t1_rst_m_src",  bus.m_src, 0);
    check("t1_rst_last",   bus.m_last, 0);
    rst = 1'b0;
    tick;

    // full 4-beat transfer
    bus.ch_cnt = 8'd4; bus.ch_go = 1'b1; tick; bus.ch_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_start0", bus.ss_start0, 1);
      bus.ss_xfer0 = 1'b1; bus.wbs_dat_o0 = 16'h1000 + 16'(i);
      #1 check("t2_end0", bus.ss_end0, (i == 3) ? 1 : 0);
      tick;
    end
    bus.ss_xfer0 = 1'b0;
    check("t2_start0_off", bus.ss_start0, 0);
    for (int i = 0; i < 4; i++) begin
      v = 16'h1000 + 16'(i);
      check("t2_src_empty", bus.m_src_empty, 0);
      check("t2_src_data",  bus.m_src, v);
      check("t2_last",      bus.m_last, (i == 3) ? 1 : 0);
      bus.m_src_getn = 1'b0; bus.m_dst_putn = 1'b0; bus.m_dst = v ^ 16'h00FF;
      tick;
    end
    bus.m_src_getn = 1'b1; bus.m_dst_putn = 1'b1;
    check("t2_src_drained", bus.m_src_empty, 1);
    for (int i = 0; i < 4; i++) begin
      v = (16'h1000 + 16'(i)) ^ 16'h00FF;
      check("t2_start1",   bus.ss_start1, 1);
      check("t2_dst_data", bus.wbs_dat_i1, v);
      bus.ss_xfer1 = 1'b1;
      #1 check("t2_end1", bus.ss_end1, (i == 3) ? 1 : 0);
      check("t2_done_early", bus.ch_done, 0);
      tick;
    end
    bus.ss_xfer1 = 1'b0;
    check("t2_done",       bus.ch_done, 1);
    check("t2_busy_off",   bus.ch_busy, 0);
    check("t2_start1_off", bus.ss_start1, 0);
    tick;
    check("t2_done_pulse", bus.ch_done, 0);

    // AW=2 full behaviour
    bus.ch_cnt = 8'd6; bus.ch_go = 1'b1; tick; bus.ch_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ss_xfer0 = 1'b1; bus.wbs_dat_o0 = 16'h2000 + 16'(i); tick;
    end
    check("t3_full_start0", bus.ss_start0, 0);
    bus.wbs_dat_o0 = 16'h2004; tick;
    bus.m_src_getn = 1'b0; bus.wbs_dat_o0 = 16'h2005;
    check("t3_pushpop_head", bus.m_src, 16'h2000);
    tick;
    bus.ss_xfer0 = 1'b0; bus.m_src_getn = 1'b1;
    check("t3_still_full", bus.ss_start0, 0);
    for (int i = 1; i < 3; i++) begin
      v = 16'h2000 + 16'(i);
      check("t3_order", bus.m_src, v);
      bus.m_src_getn = 1'b0; bus.m_dst_putn = 1'b0; bus.m_dst = v ^ 16'h00FF;
      tick;
    end
    bus.m_src_getn = 1'b1; bus.m_dst_putn = 1'b1;
    check("t3_head3",     bus.m_src, 16'h2003);
    check("t3_start0_on", bus.ss_start0, 1);
    check("t3_dst_head",  bus.wbs_dat_i1, 16'h2001 ^ 16'h00FF);
    check("t3_dst_full",  bus.m_dst_full, 0);

    // abort with 2 beats in each FIFO
    bus.ch_abort = 1'b1; tick; bus.ch_abort = 1'b0;
    check("t4_src_empty", bus.m_src_empty, 1);
    check("t4_dst_empty", bus.ss_start1, 0);
    check("t4_busy",      bus.ch_busy, 0);
    check("t4_done",      bus.ch_done, 0);
    check("t4_start0",    bus.ss_start0, 0);
    check("t4_err",       bus.ch_err, 0);
    tick;
    check("t4_done2", bus.ch_done, 0);
    bus.ch_cnt = 8'd1; bus.ch_go = 1'b1; tick; bus.ch_go = 1'b0;
    check("t4_busy_new", bus.ch_busy, 1);
    bus.ss_xfer0 = 1'b1; bus.wbs_dat_o0 = 16'h3000;
    #1 check("t4_end0", bus.ss_end0, 1);
    check("t4_latency", bus.m_src_empty, 1);
    tick;
    bus.ss_xfer0 = 1'b0;
    check("t4_fwft_empty", bus.m_src_empty, 0);
    check("t4_fwft_data",  bus.m_src, 16'h3000);
    check("t4_fwft_last",  bus.m_last, 1);
    check("t4_start0_off", bus.ss_start0, 0);
    bus.m_src_getn = 1'b0; bus.m_dst_putn = 1'b0; bus.m_dst = 16'h3000 ^ 16'h00FF;
    tick;
    bus.m_src_getn = 1'b1; bus.m_dst_putn = 1'b1;
    check("t4_src_drained", bus.m_src_empty, 1);
    check("t4_dst_data",    bus.wbs_dat_i1, 16'h30FF);
    bus.ss_xfer1 = 1'b1;
    #1 check("t4_end1", bus.ss_end1, 1);
    tick;
    bus.ss_xfer1 = 1'b0;
    check("t4_done_new", bus.ch_done, 1);
    tick;
    check("t4_done_pulse", bus.ch_done, 0);
    check("t4_idle",       bus.ch_busy, 0);

    // zero-count go and go while busy
    bus.ch_cnt = 8'd0; bus.ch_go = 1'b1; tick; bus.ch_go = 1'b0;
    check("t5_zero_done", bus.ch_done, 1);
    check("t5_zero_busy", bus.ch_busy, 0);
    tick;
    check("t5_zero_done_pulse", bus.ch_done, 0);
    check("t5_zero_busy2",      bus.ch_busy, 0);
    bus.ch_cnt = 8'd2; bus.ch_go = 1'b1; tick;
    check("t5_busy", bus.ch_busy, 1);
    bus.ch_cnt = 8'd5; tick; bus.ch_go = 1'b0;
    check("t5_busy_kept", bus.ch_busy, 1);
    for (int i = 0; i < 2; i++) begin
      bus.ss_xfer0 = 1'b1; bus.wbs_dat_o0 = 16'h5000 + 16'(i);
      #1 check("t5_end0_cnt", bus.ss_end0, (i == 1) ? 1 : 0);
      tick;
    end
    bus.ss_xfer0 = 1'b0;
    check("t5_cnt_reached", bus.ss_start0, 0);
    bus.ch_abort = 1'b1; tick; bus.ch_abort = 1'b0;

    // error flag: pop on empty source
    check("t6_err_clear", bus.ch_err, 0);
    bus.m_src_getn = 1'b0; tick; bus.m_src_getn = 1'b1;
    check("t6_err_set", bus.ch_err, ERR_EXP);
    tick;
    check("t6_err_held", bus.ch_err, ERR_EXP);
    bus.ch_abort = 1'b1; tick; bus.ch_abort = 1'b0;
    check("t6_err_abort", bus.ch_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ss_chan_buf.md
Name: ss_chan_buf

Overview:
- Parametrised next-generation DMA channel data buffer.
- Source FIFO carries source-bus beats to the processing module; destination FIFO carries module results back to the sink bus.
- Adds a per-transfer beat count, last-beat tagging, full/empty flow control, start/end handshakes, a channel FSM with done and abort, and configurable width and depth.
- Sits between the slave-side transfer engine and one processing module, one instance per channel.

Parameters:
DW, 64, data width of both FIFOs and all data ports.
AW, 9, FIFO address width; depth = 2**AW entries per FIFO.
CW, 24, transfer beat-count width.

Ports:
wb_clk_i  in  1  clock; the only clock.
wb_rst_i  in  1  reset, asynchronous, active-high.
ch_go  in  1  start pulse; latches ch_cnt.
ch_cnt  in  CW  beats to transfer, in DW-bit units.
ch_abort  in  1  synchronous abort/clear.
ch_busy  out  1  channel active.
ch_done  out  1  one-cycle completion pulse.
ch_err  out  1  sticky protocol error (optional feature).
ss_start0  out  1  source request: space available and source beats remain.
ss_xfer0  in  1  source beat strobe.
wbs_dat_o0  in  DW  source data.
ss_end0  out  1  pulse: final source beat accepted.
m_src_getn  in  1  active-low pop from source FIFO.
m_src  out  DW  source FIFO head.
m_last  out  1  head is the final beat of the transfer.
m_src_empty  out  1  source FIFO empty.
m_dst_putn  in  1  active-low push into destination FIFO.
m_dst  in  DW  destination data.
m_dst_full  out  1  destination FIFO full.
ss_start1  out  1  sink request: destination FIFO non-empty.
ss_xfer1  in  1  sink beat strobe; pops destination FIFO.
wbs_dat_i1  out  DW  destination FIFO head.
ss_end1  out  1  pulse: final sink beat popped.

Behaviour:
- Reset: all flags, counters and outputs 0, except m_src_empty=1. FSM in IDLE. FIFOs empty.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on ch_go with ch_cnt!=0. Latch cnt; clear the src-written counter (sw) and dst-read counter (dr).
  - ch_go with ch_cnt==0: ch_done pulses on the next cycle; FSM stays IDLE.
  - ch_go while busy is ignored.
- ch_busy = (state==RUN).
- Source side:
  - ss_start0 = RUN & ~src_full & (sw<cnt).
  - A beat is written on ss_xfer0 & ~src_full & (sw<cnt); sw increments.
  - The entry stores DW data plus a last bit, set when sw==cnt-1.
  - ss_end0 pulses in the cycle the last-tagged beat is written.
- Source FIFO is first-word-fall-through:
  - m_src and m_last are valid whenever m_src_empty=0.
  - Pop on ~m_src_getn & ~m_src_empty.
  - After a push into an empty FIFO, m_src_empty deasserts the next cycle (one-cycle write-to-read latency).
- Destination side:
  - Push on ~m_dst_putn & ~m_dst_full.
  - ss_start1 = ~dst_empty; wbs_dat_i1 is the head, first-word-fall-through.
  - Pop on ss_xfer1 & ~dst_empty; dr increments.
  - ss_end1 pulses on the pop where dr==cnt-1.
- RUN -> DONE on the ss_end1 cycle. DONE -> IDLE after one cycle; ch_done=1 in DONE.
- Full/empty flags are derived from pointers with an extra wrap bit; pointers wrap modulo 2**AW.
- Simultaneous push and pop:
  - When full: both occur; the flag stays full.
  - When empty: push only; the pop is ignored.
- Push while full or pop while empty: no state change.
- ch_abort (any state): pointers, sw, dr and flags reset to reset values; FSM -> IDLE; no ch_done. ch_abort has priority over ch_go in the same cycle.
- wb_rst_i asserted mid-transfer: immediate return to reset state; in-flight data discarded.
- Counters are CW bits wide; cnt=2**CW-1 must complete without overflow.

Optional Feature:
- Macro SS_CHAN_ERR_EN.
- Defined: ch_err sets on any of the following and stays set until wb_rst_i, ch_abort, or ch_go from IDLE:
  - ss_xfer0 while src full or sw==cnt;
  - ~m_src_getn while src empty;
  - ~m_dst_putn while dst full;
  - ss_xfer1 while dst empty.
- Undefined: ch_err is tied 0 and no detection logic is built.

Test Plan:
- Reset mid-RUN with 3 beats queued -> all outputs at reset values, m_src_empty=1, ch_busy=0.
- ch_cnt=4, source writes 4 beats, module pops and echoes them, sink pops -> ss_end0 on beat 4, m_last=1 only with beat 4 at head, ss_end1 on pop 4, ch_done one cycle later.
- AW=2: write 4 beats without popping -> src_full, ss_start0=0; a 5th ss_xfer0 is dropped; then simultaneous push/pop at full -> count stays 4, data order preserved.
- ch_cnt=0 go -> ch_done the next cycle, ch_busy never asserts; ch_go during RUN -> ignored, cnt unchanged.
- ch_abort with 2 beats in each FIFO -> both FIFOs empty next cycle, FSM IDLE, no ch_done; new ch_cnt=1 transfer then completes normally.
- SS_CHAN_ERR_EN defined: pop on empty src -> ch_err=1 held until ch_abort; undefined build -> ch_err stays 0.
